io_periph_bank: RTL and testbench

IO_PERIPH_BANK -- requirements
Module: io_periph_bank

---
 rtl/io_pkg.sv | 71 +++++++
 rtl/sw_debounce.sv | 54 +++++
 rtl/io_periph_bank.sv | 167 ++++++++++++++++
 tb/tb_io_periph_bank.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the IO peripheral bank: access-size encodings,
// register index map and byte-lane helper functions.
package io_pkg;

  // Load/store size and sign encodings carried on funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Address bit 16 selects the region
  localparam logic REGION_OUT = 1'b0;
  localparam logic REGION_IN  = 1'b1;

  // Output-region register indices
  localparam int IDX_LEDR  = 0;
  localparam int IDX_LEDG  = 1;
  localparam int IDX_HEX30 = 2;
  localparam int IDX_HEX54 = 3;
  localparam int IDX_LCD   = 4;

  // Input-region register indices
  localparam int IDX_SW   = 0;
  localparam int IDX_STAT = 1;
  localparam int IDX_IEN  = 2;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // Unknown encodings fall back to a full word access
  function automatic size_e decode_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return (off == 2'd3);
      SZ_WORD: return (off != 2'd0);
      default: return 1'b0;
    endcase
  endfunction

  // One bit per byte lane touched by the access
  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] expand_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Replace only the bits selected by bit_mask
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] bit_mask);
    return (old_val & ~bit_mask) | (new_val & bit_mask);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-bit switch debouncer: two-flop synchroniser followed by a
// stability counter. o_toggle is high in the cycle whose rising edge
// flips o_stable, so status logic can latch it on that same edge.
module sw_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  output logic o_stable,
  output logic o_toggle
);

  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             w_differ;

  assign w_differ = r_sync2 ^ r_stable;
  assign o_toggle = w_differ && (r_cnt == CNT_LAST);
  assign o_stable = r_stable;

  // Bring the asynchronous switch into the clock domain
  // NOTE: non-blocking assignments make r_sync2 take the old r_sync1, giving two real flops.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive cycles of disagreement; any bounce restarts the window
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (!w_differ) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt    <= '0;
      r_stable <= ~r_stable;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/io_periph_bank.sv
// Memory-mapped IO bank: byte-lane writable output registers driving LEDs,
// seven-segment digits and LCD, plus an input region with debounced
// switches, W1C change status and an interrupt enable mask.
module io_periph_bank
  import io_pkg::*;
#(
  parameter int N_OUT     = 8,
  parameter int SW_W      = 32,
  parameter int DB_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wren,
  input  logic [16:0]           i_address,
  input  logic [2:0]            funct3,
  input  logic [31:0]           i_data,
  output logic [31:0]           o_data,
  input  logic [SW_W-1:0]       i_io_sw,
  output logic [31:0]           o_io_ledr,
  output logic [31:0]           o_io_ledg,
  output logic [31:0]           o_io_lcd,
  output logic [6:0]            o_io_hex0,
  output logic [6:0]            o_io_hex1,
  output logic [6:0]            o_io_hex2,
  output logic [6:0]            o_io_hex3,
  output logic [6:0]            o_io_hex4,
  output logic [6:0]            o_io_hex5,
  output logic [N_OUT*32-1:0]   o_out_flat,
  output logic                  o_irq,
  output logic                  o_misaligned
);

  // Only the low SW_W bits of status/enable exist
  localparam logic [31:0] SW_MASK = 32'((64'd1 << SW_W) - 64'd1);

  logic [N_OUT-1:0][31:0] r_out;
  logic [31:0]            r_stat;
  logic [31:0]            r_ien;
  logic                   r_misaligned;

  logic                   w_region;
  logic [3:0]             w_idx;
  logic [1:0]             w_off;
  size_e                  w_size;
  logic                   w_misalign;
  logic [31:0]            w_bitmask;
  logic [31:0]            w_wdata;
  logic                   w_out_wr;
  logic                   w_in_wr;
  logic [31:0]            w_w1c;
  logic [SW_W-1:0]        w_stable;
  logic [SW_W-1:0]        w_toggle;
  logic [31:0]            w_sw_word;
  logic [31:0]            w_toggle_word;
  logic [31:0]            w_rd_word;
  logic [31:0]            w_rd_shift;
  logic                   w_unused_addr;

  // Address and access decode
  assign w_region      = i_address[16];
  assign w_idx         = i_address[15:12];
  assign w_off         = i_address[1:0];
  assign w_unused_addr = &{1'b0, i_address[11:2]};
  assign w_size        = decode_size(funct3);
  assign w_misalign    = is_misaligned(w_size, w_off);
  assign w_bitmask     = expand_mask(lane_mask(w_size, w_off));
  assign w_wdata       = i_data << {w_off, 3'b000};
  assign w_out_wr      = i_wren && (w_region == REGION_OUT) && !w_misalign;
  assign w_in_wr       = i_wren && (w_region == REGION_IN) && !w_misalign;
  assign w_w1c         = (w_in_wr && int'(w_idx) == IDX_STAT) ? (w_wdata & w_bitmask) : '0;

  // One debouncer per switch bit
  for (genvar g = 0; g < SW_W; g++) begin : g_db
    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_sw     (i_io_sw[g]),
      .o_stable (w_stable[g]),
      .o_toggle (w_toggle[g])
    );
  end

  assign w_sw_word     = 32'(w_stable);
  assign w_toggle_word = 32'(w_toggle);

  // Output register file with per-lane writes; out-of-range indices are dropped
  // NOTE: this is a bank of flops feeding pins, not a RAM, so every entry is reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_out <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (w_out_wr && int'(w_idx) == k) begin
          r_out[k] <= merge_lanes(r_out[k], w_wdata, w_bitmask);
        end
      end
    end
  end

  // Change status (toggle sets, W1C clears, set wins) and interrupt enable
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_stat <= '0;
      r_ien  <= '0;
    end else begin
      r_stat <= ((r_stat & ~w_w1c) | w_toggle_word) & SW_MASK;
      if (w_in_wr && int'(w_idx) == IDX_IEN) begin
        r_ien <= merge_lanes(r_ien, w_wdata, w_bitmask) & SW_MASK;
      end
    end
  end

  // Flag a rejected misaligned store for one cycle
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= i_wren && w_misalign;
    end
  end

  // Select the addressed register word for a load
  // NOTE: assigning a default first keeps this block purely combinational on every path.
  always_comb begin
    w_rd_word = '0;
    if (w_region == REGION_OUT) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (int'(w_idx) == k) w_rd_word = r_out[k];
      end
    end else begin
      case (int'(w_idx))
        IDX_SW:   w_rd_word = w_sw_word;
        IDX_STAT: w_rd_word = r_stat;
        IDX_IEN:  w_rd_word = r_ien;
        default:  w_rd_word = '0;
      endcase
    end
  end

  assign w_rd_shift = w_rd_word >> {w_off, 3'b000};

  // Right-align and extend the load data; misaligned loads read zero
  always_comb begin
    o_data = '0;
    if (!w_misalign) begin
      case (w_size)
        SZ_BYTE: o_data = {{24{w_rd_shift[7] & ~funct3[2]}}, w_rd_shift[7:0]};
        SZ_HALF: o_data = {{16{w_rd_shift[15] & ~funct3[2]}}, w_rd_shift[15:0]};
        default: o_data = w_rd_shift;
      endcase
    end
  end

  assign o_io_ledr    = r_out[IDX_LEDR];
  assign o_io_ledg    = r_out[IDX_LEDG];
  assign o_io_lcd     = r_out[IDX_LCD];
  assign o_io_hex0    = r_out[IDX_HEX30][6:0];
  assign o_io_hex1    = r_out[IDX_HEX30][14:8];
  assign o_io_hex2    = r_out[IDX_HEX30][22:16];
  assign o_io_hex3    = r_out[IDX_HEX30][30:24];
  assign o_io_hex4    = r_out[IDX_HEX54][6:0];
  assign o_io_hex5    = r_out[IDX_HEX54][14:8];
  assign o_out_flat   = r_out;
  assign o_irq        = |(r_stat & r_ien);
  assign o_misaligned = r_misaligned;

endmodule

// File: tb/tb_io_periph_bank.sv
// Directed bench for io_periph_bank: stimulus pushes expected values into a
// scoreboard queue, a monitor compares them on the falling clock edge.
module tb_io_periph_bank;
  import io_pkg::*;

  localparam int N_OUT = 8;
  localparam int SW_W  = 32;
  localparam int DB    = 16;

  localparam int SEL_DATA = 0;
  localparam int SEL_LEDR = 1;
  localparam int SEL_LEDG = 2;
  localparam int SEL_LCD  = 3;
  localparam int SEL_HEX  = 4;
  localparam int SEL_IRQ  = 5;
  localparam int SEL_MIS  = 6;

  logic                 clk;
  logic                 i_rst;
  logic                 i_wren;
  logic [16:0]          i_address;
  logic [2:0]           funct3;
  logic [31:0]          i_data;
  logic [31:0]          o_data;
  logic [SW_W-1:0]      i_io_sw;
  logic [31:0]          o_io_ledr, o_io_ledg, o_io_lcd;
  logic [6:0]           o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3, o_io_hex4, o_io_hex5;
  logic [N_OUT*32-1:0]  o_out_flat;
  logic                 o_irq;
  logic                 o_misaligned;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  io_periph_bank #(.N_OUT(N_OUT), .SW_W(SW_W), .DB_CYCLES(DB)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_wren       (i_wren),
    .i_address    (i_address),
    .funct3       (funct3),
    .i_data       (i_data),
    .o_data       (o_data),
    .i_io_sw      (i_io_sw),
    .o_io_ledr    (o_io_ledr),
    .o_io_ledg    (o_io_ledg),
    .o_io_lcd     (o_io_lcd),
    .o_io_hex0    (o_io_hex0),
    .o_io_hex1    (o_io_hex1),
    .o_io_hex2    (o_io_hex2),
    .o_io_hex3    (o_io_hex3),
    .o_io_hex4    (o_io_hex4),
    .o_io_hex5    (o_io_hex5),
    .o_out_flat   (o_out_flat),
    .o_irq        (o_irq),
    .o_misaligned (o_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      SEL_DATA: return 64'(o_data);
      SEL_LEDR: return 64'(o_io_ledr);
      SEL_LEDG: return 64'(o_io_ledg);
      SEL_LCD:  return 64'(o_io_lcd);
      SEL_HEX:  return 64'({o_io_hex5, o_io_hex4, o_io_hex3, o_io_hex2, o_io_hex1, o_io_hex0});
      SEL_IRQ:  return 64'(o_irq);
      SEL_MIS:  return 64'(o_misaligned);
      default:  return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  // Monitor: compare every pending expectation on the falling edge
  initial begin
    exp_t        e;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = observe(e.sel);
        n_checks++;
        if (act !== e.exp) begin
          n_errors++;
          $display("FAIL %s: actual=0x%0h required=0x%0h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int sel, input logic [63:0] val, input string name);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = val;
    q.push_back(e);
  endtask

  // Wait for the monitor to consume all expectations, bounded
  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout: actual=%0d pending required=0", q.size());
      q.delete();
    end
  endtask

  task automatic store(input logic [16:0] a, input logic [2:0] f, input logic [31:0] d);
    i_address = a;
    funct3    = f;
    i_data    = d;
    i_wren    = 1'b1;
    cyc(1);
    i_wren    = 1'b0;
  endtask

  task automatic load(input logic [16:0] a, input logic [2:0] f);
    i_address = a;
    funct3    = f;
    i_wren    = 1'b0;
  endtask

  task automatic check_load(input logic [16:0] a, input logic [2:0] f,
                            input logic [31:0] val, input string name);
    load(a, f);
    push(SEL_DATA, 64'(val), name);
    drain();
  endtask

  initial begin
    i_rst     = 1'b0;
    i_wren    = 1'b0;
    i_address = '0;
    funct3    = F3_W;
    i_data    = '0;
    i_io_sw   = '0;

    // Reset state
    cyc(3);
    load(17'h10000, F3_W);
    push(SEL_DATA, 64'h0, "rst_data");
    push(SEL_LEDR, 64'h0, "rst_ledr");
    push(SEL_IRQ,  64'h0, "rst_irq");
    push(SEL_MIS,  64'h0, "rst_mis");
    drain();
    cyc(1);
    i_rst = 1'b1;
    cyc(1);

    // Byte-lane writes and sign/zero-extended loads
    store(17'h01000, F3_W, 32'h1122_3344);
    store(17'h01002, F3_B, 32'h0000_00AA);
    push(SEL_LEDG, 64'h11AA_3344, "ledg_sb");
    drain();
    check_load(17'h01002, F3_B,   32'hFFFF_FFAA, "lb");
    check_load(17'h01002, F3_BU,  32'h0000_00AA, "lbu");
    check_load(17'h01002, F3_H,   32'h0000_11AA, "lh_off2");
    check_load(17'h01001, F3_H,   32'hFFFF_AA33, "lh_off1");
    check_load(17'h01001, F3_HU,  32'h0000_AA33, "lhu_off1");
    check_load(17'h01000, 3'b111, 32'h11AA_3344, "lw_other_f3");

    // Misaligned stores are rejected and pulse o_misaligned for one cycle
    store(17'h00000, F3_W, 32'hFFFF_FFFF);
    push(SEL_MIS,  64'h0, "mis_aligned_sw");
    push(SEL_LEDR, 64'hFFFF_FFFF, "ledr_sw");
    drain();
    store(17'h00003, F3_H, 32'h0000_1234);
    push(SEL_MIS,  64'h1, "mis_sh_pulse");
    push(SEL_LEDR, 64'hFFFF_FFFF, "ledr_keep_sh");
    drain();
    cyc(1);
    push(SEL_MIS, 64'h0, "mis_one_cycle");
    drain();
    store(17'h00002, F3_W, 32'h0000_0000);
    push(SEL_MIS,  64'h1, "mis_sw_pulse");
    push(SEL_LEDR, 64'hFFFF_FFFF, "ledr_keep_sw");
    drain();
    check_load(17'h00003, F3_H, 32'h0, "lh_misaligned");
    check_load(17'h00001, F3_W, 32'h0, "lw_misaligned");
    check_load(17'h00002, F3_H, 32'hFFFF_FFFF, "lh_aligned_hi");

    // Out-of-range output index
    store(17'h08000, F3_W, 32'hDEAD_BEEF);
    push(SEL_LEDR, 64'hFFFF_FFFF, "ledr_idx8");
    drain();
    check_load(17'h08000, F3_W, 32'h0, "lw_idx8");

    // Seven-segment and LCD mapping
    store(17'h02000, F3_W, 32'h7F06_3F5B);
    store(17'h03000, F3_H, 32'h0000_8281);
    store(17'h04000, F3_W, 32'hCAFE_F00D);
    push(SEL_HEX, 64'({7'h02, 7'h01, 7'h7F, 7'h06, 7'h3F, 7'h5B}), "hex_map");
    push(SEL_LCD, 64'hCAFE_F00D, "lcd");
    drain();

    // Interrupt enable with lane writes; switch register is read-only
    store(17'h12000, F3_W, 32'h0000_0001);
    store(17'h12001, F3_B, 32'h0000_0080);
    check_load(17'h12000, F3_W, 32'h0000_8001, "ien_sb");
    store(17'h12000, F3_W, 32'h0000_0001);
    store(17'h10000, F3_W, 32'hFFFF_FFFF);
    push(SEL_IRQ, 64'h0, "irq_idle");
    drain();
    check_load(17'h10000, F3_W, 32'h0, "sw_readonly");
    check_load(17'h13000, F3_W, 32'h0, "in_idx3");

    // Clean rising edge on bit0: stable after exactly DB+2 clocks
    cyc(1);
    i_io_sw = 32'h1;
    load(17'h10000, F3_W);
    cyc(DB + 1);
    push(SEL_DATA, 64'h0, "db_rise_early");
    push(SEL_IRQ,  64'h0, "irq_early");
    drain();
    cyc(1);
    push(SEL_DATA, 64'h1, "db_rise_exact");
    push(SEL_IRQ,  64'h1, "irq_on_toggle");
    drain();
    check_load(17'h11000, F3_W, 32'h1, "stat_set");

    // W1C clears status and drops o_irq on the same edge
    store(17'h11000, F3_W, 32'h1);
    push(SEL_IRQ,  64'h0, "irq_w1c");
    push(SEL_DATA, 64'h0, "stat_w1c");
    drain();

    // Toggle and W1C on the same edge: set wins
    cyc(1);
    i_io_sw = 32'h0;
    cyc(DB + 1);
    store(17'h11000, F3_W, 32'h1);
    push(SEL_DATA, 64'h1, "stat_set_wins");
    push(SEL_IRQ,  64'h1, "irq_set_wins");
    drain();
    check_load(17'h10000, F3_W, 32'h0, "db_fall");
    store(17'h11000, F3_W, 32'h1);
    push(SEL_IRQ, 64'h0, "irq_w1c2");
    drain();

    // Bounce 1-0-1: window restarts from the final edge
    cyc(1);
    i_io_sw = 32'h1;
    cyc(5);
    i_io_sw = 32'h0;
    cyc(3);
    i_io_sw = 32'h1;
    load(17'h10000, F3_W);
    cyc(DB + 1);
    push(SEL_DATA, 64'h0, "bounce_early");
    drain();
    cyc(1);
    push(SEL_DATA, 64'h1, "bounce_exact");
    drain();
    check_load(17'h11000, F3_W, 32'h1, "bounce_stat");
    store(17'h11000, F3_W, 32'h1);
    cyc(20);
    check_load(17'h11000, F3_W, 32'h0, "bounce_stat_once");

    // Asynchronous reset mid-window
    cyc(1);
    i_io_sw = 32'h3;
    load(17'h10000, F3_W);
    cyc(10);
    #1;
    i_rst = 1'b0;
    #1;
    push(SEL_LEDR, 64'h0, "arst_ledr");
    push(SEL_LCD,  64'h0, "arst_lcd");
    push(SEL_HEX,  64'h0, "arst_hex");
    push(SEL_DATA, 64'h0, "arst_sw");
    push(SEL_IRQ,  64'h0, "arst_irq");
    push(SEL_MIS,  64'h0, "arst_mis");
    drain();
    cyc(2);
    i_rst = 1'b1;
    cyc(DB + 1);
    push(SEL_DATA, 64'h0, "post_rst_early");
    drain();
    cyc(1);
    push(SEL_DATA, 64'h3, "post_rst_exact");
    drain();
    check_load(17'h12000, F3_W, 32'h0, "post_rst_ien");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
